// File: rtl/fcmp_pkg.sv
// Shared types for the single-precision compare pipeline: op codes, operand classes, canonical NaN.
// Pure declarations and helper functions; no state.
// Build option FCMP_NAN_EN enables IEEE NaN handling in fcmp_core/fcmp_pipe.
package fcmp_pkg;

  typedef enum logic [2:0] {
    FEQ  = 3'd0,
    FLT  = 3'd1,
    FLE  = 3'd2,
    FMIN = 3'd3,
    FMAX = 3'd4
  } fcmp_op_t;

  // Encoded in ascending order so a plain unsigned compare of two classes orders them.
  typedef enum logic [1:0] {
    CLS_NEG  = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_POS  = 2'd2
  } fcmp_cls_t;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // A zero exponent folds +/-0 and every denormal into one class.
  function automatic fcmp_cls_t fcmp_classify(input logic [31:0] x);
    if (x[30:23] == 8'h00) begin
      return CLS_ZERO;
    end else if (x[31]) begin
      return CLS_NEG;
    end else begin
      return CLS_POS;
    end
  endfunction

  function automatic logic fcmp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fcmp_core.sv
// Classifies two operands and produces le/lt/eq (and per-operand NaN flags with FCMP_NAN_EN).
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module fcmp_core
  import fcmp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        le,
  output logic        lt,
  output logic        eq
`ifdef FCMP_NAN_EN
  ,
  output logic [1:0]  nan
`endif
);

  fcmp_cls_t cls_a;
  fcmp_cls_t cls_b;

  // Order by class first; within POS larger magnitude is greater, within NEG smaller magnitude is greater.
  always_comb begin
    cls_a = fcmp_classify(a);
    cls_b = fcmp_classify(b);
    lt    = 1'b0;
    eq    = 1'b0;
    if (cls_a != cls_b) begin
      lt = (cls_a < cls_b);
    end else begin
      case (cls_a)
        CLS_ZERO: eq = 1'b1;
        CLS_POS: begin
          lt = (a[30:0] < b[30:0]);
          eq = (a[30:0] == b[30:0]);
        end
        default: begin
          lt = (a[30:0] > b[30:0]);
          eq = (a[30:0] == b[30:0]);
        end
      endcase
    end
    le = lt | eq;
  end

`ifdef FCMP_NAN_EN
  assign nan = {fcmp_is_nan(b), fcmp_is_nan(a)};
`endif

endmodule

// File: rtl/fcmp_pipe.sv
// FP32 compare/min/max pipeline, result STAGES cycles after acceptance; FCMP_NAN_EN adds NaN handling.
// Latency: STAGES cycles (1..4); full throughput of one op per cycle.
// Backpressure: global stall, in_ready = !(out_valid && !out_ready); all stages freeze together.
module fcmp_pipe
  import fcmp_pkg::*;
#(
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  fcmp_op_t         op,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag,
  output logic             invalid
);

  logic le;
  logic lt;
  logic eq;
  logic [31:0] res_y;
  logic        res_inv;

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0][31:0]      y_q, y_d;
  logic [STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [STAGES-1:0]            inv_q, inv_d;

`ifdef FCMP_NAN_EN
  logic [1:0] nan;

  fcmp_core u_core (
    .a   (x1),
    .b   (x2),
    .le  (le),
    .lt  (lt),
    .eq  (eq),
    .nan (nan)
  );
`else
  fcmp_core u_core (
    .a  (x1),
    .b  (x2),
    .le (le),
    .lt (lt),
    .eq (eq)
  );
`endif

  // Select the stage-1 result; FMAX uses !lt (x2 <= x1) so a ZERO-class tie keeps x1 for both min and max.
  always_comb begin
    res_inv = 1'b0;
    case (op)
      FEQ:     res_y = {31'd0, eq};
      FLT:     res_y = {31'd0, lt};
      FMIN:    res_y = le ? x1 : x2;
      FMAX:    res_y = lt ? x2 : x1;
      default: res_y = {31'd0, le};
    endcase
`ifdef FCMP_NAN_EN
    if (nan != 2'b00) begin
      res_inv = 1'b1;
      if (op == FMIN || op == FMAX) begin
        if (nan == 2'b11) begin
          res_y = CANON_NAN;
        end else if (nan[0]) begin
          res_y = x2;
        end else begin
          res_y = x1;
        end
      end else begin
        res_y = 32'd0;
      end
    end
`endif
  end

  assign out_valid = vld_q[STAGES-1];
  assign y         = y_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign invalid   = inv_q[STAGES-1];
  assign in_ready  = !(out_valid && !out_ready);

  // Shift every stage forward by one when the pipe advances, otherwise hold everything.
  always_comb begin
    vld_d = vld_q;
    y_d   = y_q;
    tag_d = tag_q;
    inv_d = inv_q;
    if (in_ready) begin
      vld_d[0] = in_valid;
      y_d[0]   = res_y;
      tag_d[0] = in_tag;
      inv_d[0] = res_inv;
      for (int i = 1; i < int'(STAGES); i++) begin
        vld_d[i] = vld_q[i-1];
        y_d[i]   = y_q[i-1];
        tag_d[i] = tag_q[i-1];
        inv_d[i] = inv_q[i-1];
      end
    end
  end

  // Pipeline registers; reset drops all in-flight entries and zeroes the presented result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      y_q   <= '0;
      tag_q <= '0;
      inv_q <= '0;
    end else begin
      vld_q <= vld_d;
      y_q   <= y_d;
      tag_q <= tag_d;
      inv_q <= inv_d;
    end
  end

endmodule

// File: tb/tb_fcmp_pipe.sv
// Scoreboard bench for fcmp_pipe with STAGES=3: driver queues expected results, monitor checks outputs.
// Latency is checked on unstalled ops; stall, reset-flush and NaN (FCMP_NAN_EN) cases are directed.
// Backpressure is driven via out_ready from the main sequence.
module tb_fcmp_pipe;
  import fcmp_pkg::*;

  localparam int STG = 3;
  localparam int TW  = 4;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  fcmp_op_t      op;
  logic [31:0]   x1;
  logic [31:0]   x2;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   y;
  logic [TW-1:0] out_tag;
  logic          invalid;

  fcmp_pipe #(.STAGES(STG), .TAG_W(TW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x1        (x1),
    .x2        (x2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_tag   (out_tag),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]   y;
    logic [TW-1:0] tag;
    logic          inv;
    bit            chk_lat;
    int            acc;
  } exp_t;

  exp_t          exp_q[$];
  int            vectors     = 0;
  int            miscompares = 0;
  logic [TW-1:0] tag_n       = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Offer one op at a negedge and push its expected result once it is accepted.
  task automatic send(input fcmp_op_t o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ey, input logic ei, input bit lat);
    int   n;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    x1       = a;
    x2       = b;
    in_tag   = tag_n;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      e.y       = ey;
      e.tag     = tag_n;
      e.inv     = ei;
      e.chk_lat = lat;
      e.acc     = cyc;
      exp_q.push_back(e);
    end
    tag_n = tag_n + 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  // Monitor: every accepted output is popped from the scoreboard and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rstn && out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output: got y=%h tag=%h, expected no output", y, out_tag);
        end else begin
          e = exp_q.pop_front();
          if (y !== e.y || out_tag !== e.tag || invalid !== e.inv ||
              (e.chk_lat && (cyc - e.acc) != STG)) begin
            miscompares++;
            $display("FAIL result: got y=%h tag=%h inv=%b lat=%0d, expected y=%h tag=%h inv=%b lat=%0d",
                     y, out_tag, invalid, cyc - e.acc, e.y, e.tag, e.inv, STG);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0]   stall_y;
    logic [TW-1:0] stall_tag;
    int            n;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    op        = FEQ;
    x1        = '0;
    x2        = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_out_tag", {28'd0, out_tag}, 32'd0);
    check("rst_invalid", {31'd0, invalid}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed compare/min/max vectors.
    send(FLE,  32'h3F800000, 32'h40000000, 32'd1,        1'b0, 1'b1);
    send(FLE,  32'h40000000, 32'h3F800000, 32'd0,        1'b0, 1'b1);
    send(FLT,  32'hBF800000, 32'hC0000000, 32'd0,        1'b0, 1'b1);
    send(FLT,  32'hC0000000, 32'hBF800000, 32'd1,        1'b0, 1'b1);
    send(FEQ,  32'h80000000, 32'h00000001, 32'd1,        1'b0, 1'b1);
    send(FMIN, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b1);
    send(FMAX, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b1);
    send(FMIN, 32'hBF800000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b1);
    send(FMAX, 32'hBF800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1);
    send(FMAX, 32'hC0000000, 32'h80000001, 32'h80000001, 1'b0, 1'b1);
    send(FLT,  32'h00000005, 32'h3F800000, 32'd1,        1'b0, 1'b1);
    send(FEQ,  32'h3F800000, 32'h3F800000, 32'd1,        1'b0, 1'b1);
    send(FEQ,  32'h3F800000, 32'h3F800001, 32'd0,        1'b0, 1'b1);
    send(fcmp_op_t'(3'd7), 32'h3F800000, 32'h40000000, 32'd1, 1'b0, 1'b1);
    send(fcmp_op_t'(3'd5), 32'h40000000, 32'h3F800000, 32'd0, 1'b0, 1'b1);
`ifdef FCMP_NAN_EN
    send(FMAX, 32'h7FC00000, 32'h3F800000, 32'h3F800000, 1'b1, 1'b1);
    send(FLE,  32'h7FC00001, 32'h3F800000, 32'd0,        1'b1, 1'b1);
    send(FMIN, 32'h7FC00000, 32'hFFC00001, CANON_NAN,    1'b1, 1'b1);
    send(FMIN, 32'h3F800000, 32'h7F800001, 32'h3F800000, 1'b1, 1'b1);
    send(FLE,  32'h7F800000, 32'h3F800000, 32'd0,        1'b0, 1'b1);
`else
    send(FMAX, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1);
    send(FLE,  32'h7FC00000, 32'h3F800000, 32'd0,        1'b0, 1'b1);
    send(FLT,  32'hFFC00000, 32'hBF800000, 32'd1,        1'b0, 1'b1);
`endif
    drain();

    // Back-to-back burst, tags 0..7, latency checked per result.
    tag_n = '0;
    for (int i = 0; i < 8; i++) begin
      send(FLE, 32'h40000000 + i, 32'h40000003, (i <= 3) ? 32'd1 : 32'd0, 1'b0, 1'b1);
    end
    drain();

    // Fill the pipe with out_ready low, hold for 5 cycles, then release.
    @(negedge clk);
    out_ready = 1'b0;
    stall_tag = tag_n;
    stall_y   = 32'hBF800000;
    send(FMIN, 32'hBF800000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0);
    send(FMAX, 32'hBF800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    send(FLT,  32'h3F800000, 32'h40000000, 32'd1,        1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_y", y, stall_y);
      check("stall_out_tag", {28'd0, out_tag}, {28'd0, stall_tag});
    end
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    // Reset pulse with two entries in flight; nothing may emerge afterwards.
    @(negedge clk);
    out_ready = 1'b0;
    send(FLE, 32'h3F800000, 32'h40000000, 32'd1, 1'b0, 1'b0);
    send(FLE, 32'h40000000, 32'h3F800000, 32'd0, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_y", y, 32'd0);
    check("mid_rst_out_tag", {28'd0, out_tag}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rstn      = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rerst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (8) @(negedge clk);
    #1;
    check("no_stale_out_valid", {31'd0, out_valid}, 32'd0);
    send(FEQ, 32'h80000000, 32'h00000000, 32'd1, 1'b0, 1'b1);
    drain();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fcmp_pipe.md
FCMP_PIPE -- requirements
Module: fcmp_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 2, meaning the number of register stages from input acceptance to output, legal range 1..4.
REQ-002 SHALL have parameter TAG_W, default 4, meaning the width of the opaque tag carried alongside each operation, legal range 1..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the offered operation is accepted this cycle.
REQ-007 SHALL have port op, input, 3 bits, of type fcmp_op_t: FEQ, FLT, FLE, FMIN or FMAX.
REQ-008 SHALL have ports x1 and x2, input, 32 bits each: IEEE-754 single-precision operands.
REQ-009 SHALL have port in_tag, input, TAG_W bits: tag for the operation.
REQ-010 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-012 SHALL have port y, output, 32 bits: the result. Compare ops give 32'd1 for true and 32'd0 for false; FMIN and FMAX give the selected operand.
REQ-013 SHALL have port out_tag, output, TAG_W bits: in_tag of the operation being presented.
REQ-014 SHALL have port invalid, output, 1 bit: NaN operand flag (see Configuration).

Function
REQ-015 SHALL classify each operand: exponent == 0 is ZERO (covers ±0 and denormals); otherwise sign 0 is POS and sign 1 is NEG; ordering is NEG < ZERO < POS.
REQ-016 SHALL order operands of the same class as follows: POS by unsigned x[30:0] ascending; NEG by unsigned x[30:0] descending; all ZERO operands are equal.
REQ-017 SHALL compute FLE, FLT and FEQ from this ordering. FEQ(+0, -0) = 1; FEQ(0x00000001, 0) = 1.
REQ-018 SHALL compute FMIN as x1 if x1 <= x2, else x2.
REQ-019 SHALL compute FMAX as x1 if x2 <= x1, else x2. On a ZERO-class tie, both FMIN and FMAX return x1 bit-exact.
REQ-020 SHALL accept an operation when in_valid && in_ready.
REQ-021 SHALL present that operation's result exactly STAGES cycles after acceptance when there is no backpressure.
REQ-022 SHALL drive in_ready = !(out_valid && !out_ready); the whole pipeline advances together or stalls together.
REQ-023 SHALL, during a stall, hold y, out_tag, invalid and out_valid stable and preserve every in-flight entry.
REQ-024 SHALL sustain a throughput of 1 op per cycle with out_ready held high; bubbles propagate as invalid stages and are not compressed.
REQ-025 SHALL deliver results in acceptance order, with tags unaltered.
REQ-026 SHALL treat an undefined op encoding as FLE.

Reset
REQ-027 SHALL, while rstn = 0, clear all stage valid bits, and drive out_valid = 0, y = 0, out_tag = 0 and invalid = 0.
REQ-028 SHALL, on reset asserted mid-operation, discard every in-flight entry without emitting it.
REQ-029 SHALL allow in_ready = 1 in the first cycle after rstn rises.

Configuration
REQ-030 SHALL, when macro FCMP_NAN_EN is defined, detect NaN (exponent 0xFF and mantissa != 0) on either operand and then:
- set invalid = 1;
- make compare ops return 0;
- make FMIN and FMAX return the non-NaN operand, or 0x7FC00000 if both operands are NaN.
REQ-031 SHALL, when FCMP_NAN_EN is undefined, give NaN and infinity no special treatment: they are ordered by REQ-015/016 as ordinary bit patterns, and invalid is tied to 0.

Structure
REQ-032 SHALL place fcmp_op_t, the class encoding (NEG/ZERO/POS) and the constant CANON_NAN = 0x7FC00000 in shared package fcmp_pkg.
REQ-033 SHALL instantiate exactly one combinational sub-module, fcmp_core (classify plus ordering, producing le, lt, eq and nan), in stage 1; the remaining stages are pure delay and stall registers.

Verification
REQ-034 SHALL cover FLE with x1 = 0x3F800000, x2 = 0x40000000 -> y = 1. Swapped operands -> y = 0. FLT(-1.0 = 0xBF800000, -2.0 = 0xC0000000) -> y = 0.
REQ-035 SHALL cover FEQ(0x80000000, 0x00000001) -> y = 1. FMIN(+0, -0) -> y = 0x00000000, i.e. x1.
REQ-036 SHALL cover, with STAGES = 3, a back-to-back burst of 8 ops carrying tags 0..7 and out_ready = 1 -> results appear on cycles 3..10 with tags 0..7 in order.
REQ-037 SHALL cover holding out_ready = 0 for 5 cycles with a full pipe -> in_ready = 0, y and out_tag stable, no loss or duplication after release.
REQ-038 SHALL cover, with FCMP_NAN_EN defined, FMAX(0x7FC00000, 0x3F800000) -> y = 0x3F800000 and invalid = 1; FLE with a NaN operand -> y = 0.
REQ-039 SHALL cover rstn pulsed low for 1 cycle with 2 entries in flight -> out_valid = 0 immediately, and no stale result appears afterwards.
